// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared constants for the CPU system bus.
// Region indices, default decode tables and FSM state encoding.
package sys_bus_pkg;

   localparam int NREG_DEF = 6;
   localparam int DIV_W    = 4;

   localparam int RGN_IO0 = 0;
   localparam int RGN_IO1 = 1;
   localparam int RGN_IO2 = 2;
   localparam int RGN_IO3 = 3;
   localparam int RGN_ROM = 4;
   localparam int RGN_HI  = 5;

   // Tables are written highest index first so index 0 lands in the LSBs.
   localparam logic [16*NREG_DEF-1:0] REG_BASE_DEF = {
      16'hD000, 16'hFF00, 16'hFE60, 16'hFE40, 16'hFE20, 16'hFE00
   };

   localparam logic [16*NREG_DEF-1:0] REG_MASK_DEF = {
      16'hE000, 16'hFF00, 16'hFFE0, 16'hFFE0, 16'hFFE0, 16'hFFE0
   };

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/sys_bus_addr_decode.sv
// addr_decode: combinational priority region match, lowest index wins.
// Ports: addr (CPU address) -> sel (one-hot or zero region select).
module addr_decode
   import sys_bus_pkg::*;
#(
   parameter int                     NREG = NREG_DEF,
   parameter logic [16*NREG-1:0]     BASE = REG_BASE_DEF,
   parameter logic [16*NREG-1:0]     MASK = REG_MASK_DEF
) (
   input  logic [15:0]     addr,
   output logic [NREG-1:0] sel
);

   logic hit;

   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (!hit && ((addr & MASK[16*i +: 16]) == BASE[16*i +: 16])) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sys_bus.sv
// sys_bus: CPU clock enable, region decode, wait states, read mux, error trap.
// Ports: clk25/rst, cpu_ce, addr/we/rdy, slv_sel/slv_we/slv_dbr, dbr, err/err_addr/err_clr.
module sys_bus
   import sys_bus_pkg::*;
#(
   parameter int                 NREG     = NREG_DEF,
   parameter int                 CPU_DIV  = 2,
   parameter logic [16*NREG-1:0] REG_BASE = REG_BASE_DEF,
   parameter logic [16*NREG-1:0] REG_MASK = REG_MASK_DEF,
   parameter logic [2*NREG-1:0]  REG_WAIT = '0
) (
   input  logic              clk25,
   input  logic              rst,
   output logic              cpu_ce,
   input  logic [15:0]       addr,
   input  logic              we,
   output logic              rdy,
   output logic [NREG-1:0]   slv_sel,
   output logic [NREG-1:0]   slv_we,
   input  logic [8*NREG-1:0] slv_dbr,
   output logic [7:0]        dbr,
   output logic              err,
   output logic [15:0]       err_addr,
   input  logic              err_clr
);

   logic [DIV_W-1:0] div;
   state_t           state;
   logic [1:0]       wait_cnt;
   logic [1:0]       w_sel;
   logic [NREG-1:0]  sel_q;
   logic             done;

   addr_decode #(
      .NREG (NREG),
      .BASE (REG_BASE),
      .MASK (REG_MASK)
   ) u_dec (
      .addr (addr),
      .sel  (slv_sel)
   );

   assign cpu_ce = (div == DIV_W'(CPU_DIV - 1));
   assign slv_we = slv_sel & {NREG{we & rdy}};

   always_comb begin
      w_sel = 2'd0;
      for (int i = 0; i < NREG; i++) begin
         if (slv_sel[i]) w_sel = REG_WAIT[2*i +: 2];
      end
   end

   always_comb begin
      dbr = 8'hFF;
      for (int i = 0; i < NREG; i++) begin
         if (sel_q[i]) dbr = dbr & slv_dbr[8*i +: 8];
      end
   end

   // done marks the CPU cycle that completes a stalled access, so the
   // still-held address is not stalled a second time.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         div      <= '0;
         state    <= RUN;
         wait_cnt <= 2'd0;
         sel_q    <= '0;
         rdy      <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
         err_addr <= 16'h0000;
      end else begin
         div <= cpu_ce ? '0 : div + 1'b1;
         if (cpu_ce) begin
            unique case (state)
               RUN: begin
                  sel_q <= slv_sel;
                  done  <= 1'b0;
                  if (!done && w_sel != 2'd0) begin
                     state    <= WAIT;
                     wait_cnt <= w_sel;
                     rdy      <= 1'b0;
                  end
               end
               WAIT: begin
                  if (wait_cnt == 2'd1) begin
                     state    <= RUN;
                     wait_cnt <= 2'd0;
                     rdy      <= 1'b1;
                     done     <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt - 2'd1;
                  end
               end
               default: ;
            endcase
         end
         // A new unmapped access beats a same-cycle clear.
         if (cpu_ce && state == RUN && slv_sel == '0) begin
            err <= 1'b1;
            if (!err || err_clr) err_addr <= addr;
         end else if (err_clr) begin
            err      <= 1'b0;
            err_addr <= 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_sys_bus.sv
// tb_sys_bus: randomized and directed checks of sys_bus against a CPU-view model.
// Model: region table lookup, per-access CE/rdy schedule, sticky error tracking.
module tb_sys_bus;

   localparam int NREG    = 6;
   localparam int CPU_DIV = 2;
   localparam logic [2*NREG-1:0] WAITS = 12'b00_00_01_00_10_00;

   logic              clk25 = 1'b0;
   logic              rst;
   logic              cpu_ce;
   logic [15:0]       addr;
   logic              we;
   logic              rdy;
   logic [NREG-1:0]   slv_sel;
   logic [NREG-1:0]   slv_we;
   logic [8*NREG-1:0] slv_dbr;
   logic [7:0]        dbr;
   logic              err;
   logic [15:0]       err_addr;
   logic              err_clr;

   int checks   = 0;
   int failures = 0;

   logic        exp_err;
   logic [15:0] exp_eaddr;

   logic [15:0] t_base [NREG] = '{16'hFE00, 16'hFE20, 16'hFE40,
                                  16'hFE60, 16'hFF00, 16'hD000};
   logic [15:0] t_mask [NREG] = '{16'hFFE0, 16'hFFE0, 16'hFFE0,
                                  16'hFFE0, 16'hFF00, 16'hE000};
   int          t_wait [NREG] = '{0, 2, 0, 1, 0, 0};

   logic we1_prev   = 1'b0;
   logic stall_seen = 1'b0;
   int   we1_rises  = 0;
   int   low_cycles = 0;

   sys_bus #(
      .NREG     (NREG),
      .CPU_DIV  (CPU_DIV),
      .REG_WAIT (WAITS)
   ) dut (
      .clk25    (clk25),
      .rst      (rst),
      .cpu_ce   (cpu_ce),
      .addr     (addr),
      .we       (we),
      .rdy      (rdy),
      .slv_sel  (slv_sel),
      .slv_we   (slv_we),
      .slv_dbr  (slv_dbr),
      .dbr      (dbr),
      .err      (err),
      .err_addr (err_addr),
      .err_clr  (err_clr)
   );

   always #5 clk25 = ~clk25;

   always @(negedge clk25) begin
      if (!rdy) begin
         stall_seen = 1'b1;
         low_cycles++;
      end
      if (stall_seen && rdy && slv_we[1] && !we1_prev) we1_rises++;
      we1_prev = slv_we[1];
   end

   function automatic int region_of(input logic [15:0] a);
      for (int i = 0; i < NREG; i++)
         if ((a & t_mask[i]) == t_base[i]) return i;
      return -1;
   endfunction

   function automatic logic [NREG-1:0] onehot(input int r);
      logic [NREG-1:0] v;
      v = '0;
      if (r >= 0) v[r] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] byte_of(input int r);
      if (r < 0) return 8'hFF;
      return slv_dbr[8*r +: 8];
   endfunction

   task automatic release_and_check();
      @(negedge clk25);
      rst = 1'b0;
      exp_err   = 1'b0;
      exp_eaddr = 16'h0000;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk25);
         checks++;
         if (cpu_ce !== (k % 2 == 1))
            $display("FAIL ce_pattern k=%0d: got %b want %b",
                     k, cpu_ce, (k % 2 == 1));
      end
   endtask

   task automatic apply_reset();
      @(negedge clk25);
      rst = 1'b1;
      #1;
      checks++;
      if (rdy !== 1'b1 || err !== 1'b0 || cpu_ce !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl: rdy=%b err=%b ce=%b want 1 0 0",
                  rdy, err, cpu_ce);
      end
      checks++;
      if (err_addr !== 16'h0000 || dbr !== 8'hFF) begin
         failures++;
         $display("FAIL reset_data: err_addr=%h dbr=%h want 0000 ff",
                  err_addr, dbr);
      end
      repeat (2) @(negedge clk25);
      release_and_check();
   endtask

   // Drives one CPU access at a negedge with cpu_ce low and follows it
   // through every CPU cycle it occupies.
   task automatic do_access(input logic [15:0] a, input logic w);
      int              r, wn, nce, guard;
      logic            exp_rdy;
      logic [NREG-1:0] oh, exp_we;
      r   = region_of(a);
      wn  = (r < 0) ? 0 : t_wait[r];
      oh  = onehot(r);
      nce = (wn > 0) ? wn + 2 : 1;
      addr = a;
      we   = w;
      #1;
      checks++;
      if (slv_sel !== oh) begin
         failures++;
         $display("FAIL slv_sel a=%h: got %b want %b", a, slv_sel, oh);
      end
      for (int k = 0; k < nce; k++) begin
         guard = 0;
         while (cpu_ce !== 1'b1 && guard < 20) begin
            @(negedge clk25);
            guard++;
         end
         checks++;
         if (guard >= 20) begin
            failures++;
            $display("FAIL ce_timeout a=%h: got no ce want ce", a);
         end
         exp_rdy = !(k >= 1 && k <= wn);
         exp_we  = (exp_rdy && w) ? oh : '0;
         checks++;
         if (rdy !== exp_rdy) begin
            failures++;
            $display("FAIL rdy a=%h k=%0d: got %b want %b", a, k, rdy, exp_rdy);
         end
         checks++;
         if (slv_we !== exp_we) begin
            failures++;
            $display("FAIL slv_we a=%h k=%0d: got %b want %b",
                     a, k, slv_we, exp_we);
         end
         if (k == 0 && r < 0) begin
            if (!exp_err) exp_eaddr = a;
            exp_err = 1'b1;
         end
         @(negedge clk25);
      end
      #1;
      checks++;
      if (dbr !== byte_of(r)) begin
         failures++;
         $display("FAIL dbr a=%h: got %h want %h", a, dbr, byte_of(r));
      end
      checks++;
      if (err !== exp_err || err_addr !== exp_eaddr) begin
         failures++;
         $display("FAIL err a=%h: got %b/%h want %b/%h",
                  a, err, err_addr, exp_err, exp_eaddr);
      end
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_read();
      slv_dbr = {$urandom, $urandom};
      slv_dbr[39:32] = 8'h5A;
      do_access(16'hFF10, 1'b0);
      checks++;
      if (slv_sel !== 6'b010000 || dbr !== 8'h5A) begin
         failures++;
         $display("FAIL read_ff10: got %b/%h want 010000/5a", slv_sel, dbr);
      end
   endtask

   task automatic test_back_to_back();
      time t0;
      do_access(16'hFE00, 1'b1);
      t0 = $time;
      do_access(16'hFE40, 1'b1);
      do_access(16'hFF80, 1'b0);
      do_access(16'hFE1F, 1'b1);
      checks++;
      if ($time - t0 != 60) begin
         failures++;
         $display("FAIL b2b_time: got %0t want 60", $time - t0);
      end
   endtask

   task automatic test_wait();
      stall_seen = 1'b0;
      we1_rises  = 0;
      low_cycles = 0;
      do_access(16'hFE21, 1'b1);
      addr = 16'hFE00;
      we   = 1'b0;
      repeat (4) @(negedge clk25);
      #1;
      checks++;
      if (we1_rises != 1) begin
         failures++;
         $display("FAIL we1_pulses: got %0d want 1", we1_rises);
      end
      checks++;
      if (low_cycles != 2 * CPU_DIV) begin
         failures++;
         $display("FAIL stall_len: got %0d want %0d", low_cycles, 2 * CPU_DIV);
      end
   endtask

   task automatic test_unmapped();
      @(negedge clk25);
      while (cpu_ce) @(negedge clk25);
      do_access(16'hC123, 1'b0);
      do_access(16'hC456, 1'b1);
      checks++;
      if (err !== 1'b1 || err_addr !== 16'hC123 || dbr !== 8'hFF) begin
         failures++;
         $display("FAIL unmapped: got %b/%h/%h want 1/c123/ff",
                  err, err_addr, dbr);
      end
   endtask

   task automatic test_err_clr();
      int guard;
      @(negedge clk25);
      addr = 16'h0010;
      we   = 1'b0;
      guard = 0;
      while (!cpu_ce && guard < 20) begin
         @(negedge clk25);
         guard++;
      end
      err_clr = 1'b1;
      @(negedge clk25);
      err_clr = 1'b0;
      addr = 16'hFE00;
      #1;
      checks++;
      if (err !== 1'b1 || err_addr !== 16'h0010) begin
         failures++;
         $display("FAIL clr_vs_set: got %b/%h want 1/0010", err, err_addr);
      end
      @(negedge clk25);
      err_clr = 1'b1;
      @(negedge clk25);
      err_clr = 1'b0;
      #1;
      checks++;
      if (err !== 1'b0 || err_addr !== 16'h0000) begin
         failures++;
         $display("FAIL clr_only: got %b/%h want 0/0000", err, err_addr);
      end
      exp_err   = 1'b0;
      exp_eaddr = 16'h0000;
   endtask

   task automatic test_rst_wait();
      int guard;
      @(negedge clk25);
      while (cpu_ce) @(negedge clk25);
      addr = 16'hFE21;
      we   = 1'b1;
      guard = 0;
      while (rdy && guard < 20) begin
         @(negedge clk25);
         guard++;
      end
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL wait_entry: got rdy=%b want 0", rdy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rdy !== 1'b1 || dut.state !== sys_bus_pkg::RUN) begin
         failures++;
         $display("FAIL rst_abort: got rdy=%b st=%b want 1 0", rdy, dut.state);
      end
      addr = 16'hFE00;
      we   = 1'b0;
      release_and_check();
   endtask

   task automatic test_random();
      int          pick;
      logic [15:0] a;
      apply_reset();
      for (int n = 0; n < 60; n++) begin
         slv_dbr = {$urandom, $urandom};
         pick = $urandom_range(0, 5);
         if (pick < 5) a = t_base[pick] | (16'($urandom) & ~t_mask[pick]);
         else a = 16'($urandom);
         do_access(a, 1'($urandom));
      end
   endtask

   initial begin
      rst     = 1'b1;
      addr    = 16'hFE00;
      we      = 1'b0;
      err_clr = 1'b0;
      slv_dbr = '0;
      exp_err   = 1'b0;
      exp_eaddr = 16'h0000;
      test_reset();
      test_read();
      test_back_to_back();
      test_wait();
      test_unmapped();
      test_err_clr();
      test_rst_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
